traveler_target_selector: RTL and testbench

Parametrised successor of the switch-driven target/channel selector. Debounces a target-ID switch bank and a channel switch bank. Range-checks the settled value and commits it to a registered target word. Each new commit is offered to the downstream transmitter over a valid/ready handshake, with overrun and range-error reporting. Sits between the board switches and the link/transmit logic.

---
 rtl/traveler_target_selector_pkg.sv | 26 ++
 rtl/traveler_target_selector_sw_debounce_core.sv | 66 ++++++
 rtl/traveler_target_selector.sv | 110 +++++++++++
 tb/tb_traveler_target_selector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traveler_target_selector_pkg.sv
// Shared definitions for the target/channel selector: debounce state encoding and
// target-word layout helpers ({has_target, id, channel}, channel in the LSBs).
package traveler_target_selector_pkg;

    typedef enum logic {
        StStable = 1'b0,
        StSettle = 1'b1
    } deb_state_e;

    localparam int unsigned ChLsb = 0;

    function automatic int unsigned target_word_width(input int unsigned id_w,
                                                      input int unsigned ch_w);
        return id_w + ch_w + 1;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned ch_w);
        return ch_w;
    endfunction

    function automatic int unsigned has_target_bit(input int unsigned id_w,
                                                   input int unsigned ch_w);
        return id_w + ch_w;
    endfunction

endpackage

// File: rtl/traveler_target_selector_sw_debounce_core.sv
// Switch-bank debouncer: 2-flop synchroniser, sample register and saturating stability
// counter; strobes settled once per stable value (or once per restart request).
module sw_debounce_core
    import traveler_target_selector_pkg::*;
#(
    parameter int unsigned WIDTH           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 5000000,
    parameter int unsigned CNT_W           = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             restart,
    output logic [WIDTH-1:0] value,
    output logic             settled
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sample_q <= '0;
            cnt_q    <= '0;
            state_q  <= StStable;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // A fresh change or a restart both wins over an evaluation due in the same cycle.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        settled  = 1'b0;
        if (sync2_q != sample_q) begin
            sample_d = sync2_q;
            cnt_d    = '0;
            state_d  = StSettle;
        end else if (restart) begin
            cnt_d   = '0;
            state_d = StSettle;
        end else if (state_q == StSettle) begin
            if (cnt_q == CntMax) begin
                settled = 1'b1;
                state_d = StStable;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign value = sample_q;

endmodule

// File: rtl/traveler_target_selector.sv
// Target/channel selector: debounced switch banks, range check, lock, committed target
// word and valid/ready update handshake with overrun and range-error pulses.
module traveler_target_selector
    import traveler_target_selector_pkg::*;
#(
    parameter int unsigned ID_W            = 5,
    parameter int unsigned CH_W            = 2,
    parameter int unsigned ID_MIN          = 1,
    parameter int unsigned ID_MAX          = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 5000000,
    parameter int unsigned CNT_W           = 23
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ID_W-1:0]                        select_switches,
    input  logic [CH_W-1:0]                        channel_switches,
    input  logic                                   lock,
    output logic [target_word_width(ID_W, CH_W)-1:0] target_word,
    output logic                                   upd_valid,
    input  logic                                   upd_ready,
    output logic                                   upd_overrun,
    output logic                                   range_err
);

    localparam int unsigned     TwW    = target_word_width(ID_W, CH_W);
    localparam int unsigned     IdLsb  = id_lsb(CH_W);
    localparam int unsigned     HasBit = has_target_bit(ID_W, CH_W);
    localparam logic [ID_W-1:0] IdMin  = ID_W'(ID_MIN);
    localparam logic [ID_W-1:0] IdMax  = ID_W'(ID_MAX);

    logic                   lock_q;
    logic                   restart;
    logic [ID_W+CH_W-1:0]   settled_raw;
    logic                   settled;
    logic [ID_W-1:0]        id;
    logic [CH_W-1:0]        ch;
    logic [TwW-1:0]         cand;
    logic [TwW-1:0]         word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   rerr_q, rerr_d;
    logic                   in_range;
    logic                   commit;

    // Releasing the lock forces a fresh evaluation of whatever is on the switches.
    assign restart = lock_q & ~lock;

    sw_debounce_core #(
        .WIDTH          (ID_W + CH_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .din    ({channel_switches, select_switches}),
        .restart(restart),
        .value  (settled_raw),
        .settled(settled)
    );

    assign id = settled_raw[ID_W-1:0];
    assign ch = settled_raw[ID_W+CH_W-1:ID_W];

    always_comb begin
        cand                 = '0;
        cand[HasBit]         = 1'b1;
        cand[IdLsb +: ID_W]  = id;
        cand[ChLsb +: CH_W]  = ch;
    end

    assign in_range = (id >= IdMin) && (id <= IdMax);
    assign commit   = settled & ~lock & in_range & (cand != word_q);

    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        rerr_d    = settled & ~lock & ~in_range;
        if (commit) begin
            word_d    = cand;
            valid_d   = 1'b1;
            // Latest wins; only flag it if the older word was never taken.
            overrun_d = valid_q & ~upd_ready;
        end else if (upd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            lock_q    <= lock;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            rerr_q    <= rerr_d;
        end
    end

    assign target_word = word_q;
    assign upd_valid   = valid_q;
    assign upd_overrun = overrun_q;
    assign range_err   = rerr_q;

endmodule

// File: tb/tb_traveler_target_selector.sv
// Self-checking bench for traveler_target_selector: vector table, corner-case sequences
// and randomized stimulus against a timestamp-based reference model.
module tb_traveler_target_selector;

    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] select_switches;
    logic [1:0] channel_switches;
    logic       lock;
    logic [7:0] target_word;
    logic       upd_valid;
    logic       upd_ready;
    logic       upd_overrun;
    logic       range_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    traveler_target_selector #(
        .ID_W           (5),
        .CH_W           (2),
        .ID_MIN         (1),
        .ID_MAX         (20),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .select_switches (select_switches),
        .channel_switches(channel_switches),
        .lock            (lock),
        .target_word     (target_word),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_overrun     (upd_overrun),
        .range_err       (range_err)
    );

    // Reference model: evaluation happens DEB edges after the last observed change of the
    // synchronised switches or the last lock release, as long as nothing intervenes.
    logic [7:0] m_word;
    logic       m_valid, m_ovr, m_rerr;
    logic [6:0] m_dq[$] = '{7'd0, 7'd0};
    logic [6:0] m_prev_raw;
    logic       m_prev_lock;
    int         m_cycle = 0;
    int         m_last  = 0;
    bit         m_pending = 1'b0;
    bit         m_known   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [6:0] raw;
        logic [7:0] cand;
        bit         commit;
        m_cycle++;
        if (rst) begin
            m_known     = 1'b1;
            m_word      = '0;
            m_valid     = 1'b0;
            m_ovr       = 1'b0;
            m_rerr      = 1'b0;
            m_dq        = '{7'd0, 7'd0};
            m_prev_raw  = '0;
            m_prev_lock = 1'b0;
            m_pending   = 1'b0;
            return;
        end
        raw = m_dq.pop_front();
        m_dq.push_back({channel_switches, select_switches});
        commit = 1'b0;
        m_ovr  = 1'b0;
        m_rerr = 1'b0;
        if (raw != m_prev_raw || (m_prev_lock && !lock)) begin
            m_pending = 1'b1;
            m_last    = m_cycle;
        end else if (m_pending && (m_cycle - m_last) == DEB) begin
            m_pending = 1'b0;
            cand = {1'b1, raw[4:0], raw[6:5]};
            if (!lock) begin
                if (int'(raw[4:0]) < 1 || int'(raw[4:0]) > 20) m_rerr = 1'b1;
                else if (cand != m_word) commit = 1'b1;
            end
        end
        m_prev_raw  = raw;
        m_prev_lock = lock;
        if (commit) begin
            m_ovr   = m_valid && !upd_ready;
            m_word  = cand;
            m_valid = 1'b1;
        end else if (upd_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_known) begin
            check("target_word", target_word, m_word);
            check("upd_valid", upd_valid, m_valid);
            check("upd_overrun", upd_overrun, m_ovr);
            check("range_err", range_err, m_rerr);
        end
    endtask

    task automatic set_sw(input int id, input int ch);
        select_switches  = 5'(id);
        channel_switches = 2'(ch);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] id;
        logic [1:0] ch;
        logic       lock;
        logic       ready;
        int         hold;
        logic [7:0] exp_word;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int first_n, vcnt, changes, ocnt, hold;
        logic [7:0] w0;

        vecs[0] = '{1'b1, 5'd0,  2'd0, 1'b0, 1'b0, 2,  8'h00, 1'b0};
        vecs[1] = '{1'b0, 5'd7,  2'd3, 1'b0, 1'b1, 12, 8'h9F, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  2'd3, 1'b0, 1'b1, 12, 8'h9F, 1'b0};
        vecs[3] = '{1'b0, 5'd25, 2'd3, 1'b0, 1'b1, 12, 8'h9F, 1'b0};
        vecs[4] = '{1'b0, 5'd12, 2'd0, 1'b1, 1'b1, 20, 8'h9F, 1'b0};
        vecs[5] = '{1'b0, 5'd12, 2'd0, 1'b0, 1'b1, 12, 8'hB0, 1'b0};
        vecs[6] = '{1'b0, 5'd9,  2'd0, 1'b0, 1'b0, 12, 8'hA4, 1'b1};
        vecs[7] = '{1'b1, 5'd9,  2'd0, 1'b0, 1'b0, 1,  8'h00, 1'b0};

        rst = 1'b1; lock = 1'b0; upd_ready = 1'b0; set_sw(0, 0);

        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst; lock = vecs[i].lock; upd_ready = vecs[i].ready;
            set_sw(int'(vecs[i].id), int'(vecs[i].ch));
            repeat (vecs[i].hold) tick();
            check($sformatf("vec%0d word", i), target_word, vecs[i].exp_word);
            check($sformatf("vec%0d valid", i), upd_valid, vecs[i].exp_valid);
        end

        // Latency after reset and a one-cycle valid with ready held high.
        rst = 1'b0; upd_ready = 1'b1; set_sw(7, 3);
        first_n = 0; vcnt = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (first_n == 0 && target_word == 8'h9F) first_n = n;
            if (upd_valid) vcnt++;
        end
        check("commit_latency", first_n, 11);
        check("valid_cycles", vcnt, 1);

        // Bouncing switches never commit; the final settled value does.
        w0 = target_word; changes = 0;
        for (int seg = 0; seg < 10; seg++) begin
            set_sw((seg % 2 == 0) ? 9 : 7, 0);
            repeat (4) begin
                tick();
                if (target_word != w0) changes++;
            end
        end
        check("toggle_commits", changes, 0);
        set_sw(9, 0); first_n = 0;
        for (int n = 1; n <= 20 && first_n == 0; n++) begin
            tick();
            if (target_word == 8'hA4) first_n = n;
        end
        check("toggle_latency", first_n, 11);

        // Overrun: second commit overwrites an unaccepted one.
        tick();
        upd_ready = 1'b0; set_sw(4, 1); ocnt = 0;
        repeat (12) begin tick(); if (upd_overrun) ocnt++; end
        set_sw(5, 1);
        repeat (12) begin tick(); if (upd_overrun) ocnt++; end
        check("overrun_pulses", ocnt, 1);
        check("overrun_word", target_word, 8'h95);
        check("overrun_valid", upd_valid, 1);
        upd_ready = 1'b1;
        tick();
        check("accept_valid", upd_valid, 0);

        // Lock holds the word; release re-evaluates the held position.
        lock = 1'b1; set_sw(12, 2); changes = 0;
        repeat (20) begin tick(); if (target_word != 8'h95) changes++; end
        check("locked_commits", changes, 0);
        lock = 1'b0; first_n = 0;
        for (int n = 1; n <= 20 && first_n == 0; n++) begin
            tick();
            if (target_word == 8'hB2) first_n = n;
        end
        check("unlock_latency", first_n, 9);

        // Reset in the middle of a pending update and a fresh settle.
        upd_ready = 1'b0; set_sw(3, 2);
        repeat (12) tick();
        check("pending_word", target_word, 8'h8E);
        set_sw(6, 2);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_word", target_word, 0);
        check("rst_valid", upd_valid, 0);
        rst = 1'b0; first_n = 0;
        for (int n = 1; n <= 20 && first_n == 0; n++) begin
            tick();
            if (target_word != 8'h00) first_n = n;
        end
        check("post_rst_latency", first_n, 11);
        check("post_rst_word", target_word, 8'h9A);

        // Randomized traffic against the model.
        for (int c = 0; c < 60; c++) begin
            set_sw(int'($urandom_range(0, 22)), int'($urandom_range(0, 3)));
            lock = ($urandom_range(0, 9) == 0);
            hold = int'($urandom_range(1, 14));
            for (int k = 0; k < hold; k++) begin
                upd_ready = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
